// File: rtl/valve_scan_scheduler.sv
// Scans N_CH valve sensors one at a time: settle, count falling edges over a window,
// then classify the count into a 3-bit note code held until the channel is next measured.
module valve_scan_scheduler #(
    parameter int          N_CH          = 3,
    parameter int          WINDOW_CYCLES = 25_000_000,
    parameter int          SETTLE_CYCLES = 1000,
    parameter int unsigned TH_LOW        = 15,
    parameter int unsigned TH_MID        = 30
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run,
    input  logic [N_CH-1:0]     sensor,
    output logic                busy,
    output logic [2:0]          ch_sel,
    output logic [3*N_CH-1:0]   codes,
    output logic [31:0]         count_last,
    output logic [N_CH-1:0]     code_valid,
    output logic                frame_done
);

    typedef enum logic [1:0] {IDLE, SETTLE, MEASURE, CLASSIFY} state_t;

    localparam logic [31:0] SETTLE_LAST = 32'(SETTLE_CYCLES - 1);
    localparam logic [31:0] WIN_LAST    = 32'(WINDOW_CYCLES - 1);
    localparam logic [31:0] TH_LOW_U    = 32'(TH_LOW);
    localparam logic [31:0] TH_MID_U    = 32'(TH_MID);
    localparam logic [2:0]  CH_LAST     = 3'(N_CH - 1);

    state_t            state;
    logic [N_CH-1:0]   sync1;
    logic [N_CH-1:0]   sync2;
    logic              sync_sel;
    logic              prev_sel;
    logic              fall;
    logic [31:0]       settle_cnt;
    logic [31:0]       win_cnt;
    logic [31:0]       count;
    logic [2:0]        code_next;

    always_comb begin
        sync_sel = 1'b1;
        for (int i = 0; i < N_CH; i++) begin
            if (ch_sel == 3'(i)) sync_sel = sync2[i];
        end
    end

    assign fall = prev_sel & ~sync_sel;
    assign busy = (state != IDLE);

    always_comb begin
        code_next = 3'd4;
        if (count <= TH_LOW_U)      code_next = 3'd2;
        else if (count <= TH_MID_U) code_next = 3'd3;
    end

    // prev_sel tracks whichever channel is selected, so a switch never pairs two channels past SETTLE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1    <= '1;
            sync2    <= '1;
            prev_sel <= 1'b1;
        end else begin
            sync1    <= sensor;
            sync2    <= sync1;
            prev_sel <= sync_sel;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            ch_sel     <= 3'd0;
            codes      <= '0;
            count_last <= '0;
            code_valid <= '0;
            frame_done <= 1'b0;
            settle_cnt <= '0;
            win_cnt    <= '0;
            count      <= '0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (run) begin
                        state      <= SETTLE;
                        ch_sel     <= 3'd0;
                        settle_cnt <= '0;
                    end
                end
                SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        state   <= MEASURE;
                        win_cnt <= '0;
                        count   <= '0;
                    end else begin
                        settle_cnt <= settle_cnt + 32'd1;
                    end
                end
                MEASURE: begin
                    if (fall && count != '1) count <= count + 32'd1;
                    if (win_cnt == WIN_LAST) state <= CLASSIFY;
                    else                     win_cnt <= win_cnt + 32'd1;
                end
                CLASSIFY: begin
                    count_last <= count;
                    settle_cnt <= '0;
                    for (int i = 0; i < N_CH; i++) begin
                        if (ch_sel == 3'(i)) begin
                            codes[3*i +: 3] <= code_next;
                            code_valid[i]   <= 1'b1;
                        end
                    end
                    // the last channel always finishes its frame before honouring run==0
                    if (ch_sel != CH_LAST) begin
                        ch_sel <= ch_sel + 3'd1;
                        state  <= SETTLE;
                    end else begin
                        frame_done <= 1'b1;
                        ch_sel     <= 3'd0;
                        state      <= run ? SETTLE : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/valve_scan_scheduler.md
Name: valve_scan_scheduler

Overview:
- Time-multiplexes one falling-edge counting window across N_CH trumpet valve sensors.
- For each channel in turn: selects it, waits a settle interval, then counts falling edges over a fixed window.
- Each count is classified into a 3-bit note code and held until that channel is next measured.
- Sits between the raw optical/valve sensors and the note/tone generator; frame_done marks a complete, coherent code set.

Parameters:
N_CH, 3, number of sensor channels scanned (2..8)
WINDOW_CYCLES, 25_000_000, clk cycles per measurement window
SETTLE_CYCLES, 1000, clk cycles after a channel switch during which edges are ignored (>=1)
TH_LOW, 15, count <= TH_LOW gives code 2
TH_MID, 30, count <= TH_MID gives code 3; above gives code 4

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-low (asserted at 0)
run  in  1  level; high = scan frames continuously
sensor  in  N_CH  raw asynchronous sensor lines, one per channel
busy  out  1  high in any state other than IDLE
ch_sel  out  3  index of the channel currently selected
codes  out  3*N_CH  packed note codes; channel k at bits [3k+2:3k]
count_last  out  32  raw edge count of the most recently classified channel
code_valid  out  N_CH  bit k set once channel k has been classified at least once since reset
frame_done  out  1  one-cycle pulse after the last channel is classified

Behaviour:
- Reset (rst=0, async):
  - FSM=IDLE; ch_sel=0; codes=0; count_last=0; code_valid=0; frame_done=0.
  - Window and settle counters = 0.
  - Synchronizer and previous-sample flops = all 1s.
- Input conditioning: each sensor bit passes through a 2-flop synchronizer. Edge detection uses only the synchronized value of the selected channel (sync_sel) against prev_sel.
  - prev_sel <= sync_sel every cycle in every state, so no false edge appears on a channel switch.
  - Falling edge = prev_sel==1 && sync_sel==0.
- FSM states: IDLE, SETTLE, MEASURE, CLASSIFY.
  - IDLE: when run==1 go to SETTLE with ch_sel=0 and settle counter cleared. run==0 holds IDLE.
  - SETTLE: runs for exactly SETTLE_CYCLES cycles, then MEASURE with window counter and edge count cleared. Edges are ignored.
  - MEASURE: runs for exactly WINDOW_CYCLES cycles.
    - An edge in any MEASURE cycle, including the last, increments count.
    - count saturates at 32'hFFFF_FFFF and never wraps.
  - CLASSIFY: one cycle.
    - codes[ch_sel] <= (count<=TH_LOW)?2 : (count<=TH_MID)?3 : 4.
    - count_last <= count; code_valid[ch_sel] <= 1.
    - If ch_sel<N_CH-1: ch_sel+1, go to SETTLE.
    - Else: frame_done=1 for this cycle, ch_sel<=0, go to SETTLE if run==1, else IDLE.
  - Edges during CLASSIFY are ignored.
- run deasserted mid-frame: the current frame completes through the last channel, then IDLE. A partial frame is never abandoned.
- run reasserted in the CLASSIFY cycle of the last channel: continues into SETTLE with no IDLE gap.
- Per-channel period = SETTLE_CYCLES + WINDOW_CYCLES + 1 cycles. Frame period = N_CH times that.
- codes and count_last change only in CLASSIFY; they hold otherwise, including through IDLE.
- Reset mid-operation discards all partial counts and every held code.
- Thresholds are compared as unsigned 32-bit values. TH_LOW < TH_MID is required.

Test Plan (WINDOW_CYCLES=100, SETTLE_CYCLES=4, N_CH=3):
1. Reset, run=1, sensor=3'b111 constant -> codes=9'b010_010_010, count_last=0, frame_done pulses at cycle 3*105 after leaving IDLE, code_valid=3'b111.
2. Channel 0: 10 edges; channel 1: 20 edges; channel 2: 40 edges, each well inside its window -> codes[2:0]=2, [5:3]=3, [8:6]=4. count_last=40 at frame_done.
3. Boundary counts 15/16/30/31 across channels over two frames -> codes 2,3,3,4. One falling edge in the final MEASURE cycle is counted. One in CLASSIFY or SETTLE is not.
4. Channel 1 held low and channel 0 held high at the switch 0->1 -> no spurious count. Channel 1 with no further edges gives count 0, code 2.
5. run dropped during channel 1 MEASURE -> channels 1 and 2 still classified, frame_done pulses once, then IDLE with busy=0 and codes held.
6. rst=0 asserted mid-MEASURE of channel 2 -> outputs immediately 0, FSM IDLE. After release with run=1, the scan restarts at ch_sel=0 with code_valid=0 until the first CLASSIFY.
